// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, address field layout,
// page length and the write sequencer state type. Used by the init, refresh, read
// and write sequencers and by the arbiter.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP    = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE = 4'b0011;
  localparam logic [3:0] CMD_WRITE  = 4'b0100;
  localparam logic [3:0] CMD_BTERM  = 4'b0110;
  localparam logic [3:0] CMD_PRECH  = 4'b0010;

  // Linear address layout: {bank, row, col}
  localparam int unsigned BA_W   = 2;
  localparam int unsigned ROW_W  = 13;
  localparam int unsigned COL_W  = 9;
  localparam int unsigned ADDR_W = BA_W + ROW_W + COL_W;

  // One full page in words
  localparam int unsigned PAGE_LEN = 512;

  // A10 high on PRECHARGE selects all banks
  localparam logic [ROW_W-1:0] PRECH_ALL_BANKS = 13'h0400;

  typedef enum logic [3:0] {
    StIdle,
    StActive,
    StTrcdWait,
    StWrite,
    StData,
    StBterm,
    StTwrWait,
    StPrech,
    StTrpWait,
    StEnd
  } wr_state_e;

endpackage

// File: rtl/sdram_write.sv
// Full-page burst write sequencer. On a grant (wr_en while init_end) it issues
// ACTIVE, WRITE with the first data beat, the remaining beats, BURST TERMINATE and
// PRECHARGE (all banks), then pulses wr_end to hand the bus back to the arbiter.
//
// Ports:
//   sdram_clk, sdram_rst_n  clock, synchronous active-low reset
//   init_end                SDRAM init complete; gates new grants only
//   wr_en                   arbiter grant, sampled in IDLE
//   wr_addr, wr_bst_len     start address {bank,row,col} and length, latched at start
//   wr_data                 show-ahead FIFO data
//   wr_ack                  FIFO pop strobe, one per data beat
//   wr_end                  one-cycle completion pulse
//   wr_cmd, wr_ba,
//   wr_sdram_addr           registered SDRAM command, bank and address
//   wr_dq, wr_dq_oe         write data (gated) and its drive enable
module sdram_write
  import sdram_pkg::*;
#(
  parameter int unsigned TRCD = 2,
  parameter int unsigned TWR  = 2,
  parameter int unsigned TRP  = 2
) (
  input  logic              sdram_clk,
  input  logic              sdram_rst_n,
  input  logic              init_end,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [9:0]        wr_bst_len,
  input  logic [15:0]       wr_data,
  output logic              wr_ack,
  output logic              wr_end,
  output logic [3:0]        wr_cmd,
  output logic [BA_W-1:0]   wr_ba,
  output logic [ROW_W-1:0]  wr_sdram_addr,
  output logic [15:0]       wr_dq,
  output logic              wr_dq_oe
);

  wr_state_e             state_q, state_d;
  logic [9:0]            cnt_q, cnt_d;
  logic [9:0]            len_q, len_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [3:0]            cmd_q, cmd_d;
  logic [BA_W-1:0]       ba_q, ba_d;
  logic [ROW_W-1:0]      addr_q, addr_d;
  logic                  ack_q, ack_d;
  logic                  end_q, end_d;

  // cnt_q counts cycles since entering a wait group, or beats issued during DATA.
  // Every output is computed one cycle ahead and registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    col_d   = col_q;
    cmd_d   = CMD_NOP;
    ba_d    = ba_q;
    addr_d  = addr_q;
    ack_d   = 1'b0;
    end_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_en && init_end) begin
          len_d = (wr_bst_len > 10'(PAGE_LEN)) ? 10'(PAGE_LEN) : wr_bst_len;
          col_d = wr_addr[COL_W-1:0];
          if (wr_bst_len == '0) begin
            // Empty burst: nothing to write, just acknowledge completion
            state_d = StEnd;
            end_d   = 1'b1;
          end else begin
            state_d = StActive;
            cmd_d   = CMD_ACTIVE;
            ba_d    = wr_addr[ADDR_W-1 -: BA_W];
            addr_d  = wr_addr[COL_W +: ROW_W];
            cnt_d   = '0;
          end
        end
      end

      StActive, StTrcdWait: begin
        if (cnt_q == 10'(TRCD - 1)) begin
          state_d = StWrite;
          cmd_d   = CMD_WRITE;
          addr_d  = {{(ROW_W - COL_W){1'b0}}, col_q};
          ack_d   = 1'b1;
          cnt_d   = 10'd1;
        end else begin
          state_d = StTrcdWait;
          cnt_d   = cnt_q + 10'd1;
        end
      end

      // Column wrap past 511 is handled by the SDRAM full-page burst itself
      StWrite, StData: begin
        if (cnt_q == len_q) begin
          state_d = StBterm;
          cmd_d   = CMD_BTERM;
          cnt_d   = '0;
        end else begin
          state_d = StData;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + 10'd1;
        end
      end

      StBterm, StTwrWait: begin
        if (cnt_q == 10'(TWR - 1)) begin
          state_d = StPrech;
          cmd_d   = CMD_PRECH;
          addr_d  = PRECH_ALL_BANKS;
          cnt_d   = '0;
        end else begin
          state_d = StTwrWait;
          cnt_d   = cnt_q + 10'd1;
        end
      end

      StPrech, StTrpWait: begin
        if (cnt_q == 10'(TRP - 1)) begin
          state_d = StEnd;
          end_d   = 1'b1;
        end else begin
          state_d = StTrpWait;
          cnt_d   = cnt_q + 10'd1;
        end
      end

      StEnd: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      col_q   <= '0;
      cmd_q   <= CMD_NOP;
      ba_q    <= '0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      col_q   <= col_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      end_q   <= end_d;
    end
  end

  assign wr_ack        = ack_q;
  assign wr_dq_oe      = ack_q;
  assign wr_end        = end_q;
  assign wr_cmd        = cmd_q;
  assign wr_ba         = ba_q;
  assign wr_sdram_addr = addr_q;
  // Only combinational output: show-ahead FIFO data straight onto DQ while driving
  assign wr_dq         = ack_q ? wr_data : 16'h0000;

endmodule

// File: tb/tb_sdram_write.sv
// Randomized self-checking bench for sdram_write. A per-cycle reference derived from
// the command timeline (ACTIVE, WRITE, beats, BT, PRECH, wr_end) is compared against
// the DUT; a show-ahead FIFO model supplies wr_data.
module tb_sdram_write;

  localparam int TRCD = 2;
  localparam int TWR  = 2;
  localparam int TRP  = 2;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WRC = 4'b0100;
  localparam logic [3:0] BTC = 4'b0110;
  localparam logic [3:0] PRC = 4'b0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_end;
  logic        wr_en;
  logic [23:0] wr_addr;
  logic [9:0]  wr_bst_len;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        wr_end;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_ba;
  logic [12:0] wr_sdram_addr;
  logic [15:0] wr_dq;
  logic        wr_dq_oe;

  int n_cmp = 0;
  int n_bad = 0;

  // Show-ahead FIFO model
  logic [15:0] fifo_mem [0:4095];
  logic [11:0] rd_ptr = '0;

  assign wr_data = fifo_mem[rd_ptr];
  always @(posedge clk) if (wr_ack) rd_ptr <= rd_ptr + 12'd1;

  always #5 clk = ~clk;

  sdram_write #(
    .TRCD(TRCD),
    .TWR (TWR),
    .TRP (TRP)
  ) dut (
    .sdram_clk    (clk),
    .sdram_rst_n  (rst_n),
    .init_end     (init_end),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_bst_len   (wr_bst_len),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .wr_end       (wr_end),
    .wr_cmd       (wr_cmd),
    .wr_ba        (wr_ba),
    .wr_sdram_addr(wr_sdram_addr),
    .wr_dq        (wr_dq),
    .wr_dq_oe     (wr_dq_oe)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare one output-visible cycle c of a burst against the timeline.
  task automatic check_cycle(input int c, input logic [23:0] a, input int le,
                             input logic [11:0] base);
    int          w;
    int          te;
    logic [3:0]  ecmd;
    logic        eack;
    logic        eend;
    logic [15:0] edq;
    w    = 1 + TRCD;
    te   = (le == 0) ? 1 : w + le + TWR + TRP;
    ecmd = NOP;
    if (le != 0) begin
      if (c == 1)              ecmd = ACT;
      else if (c == w)         ecmd = WRC;
      else if (c == w + le)    ecmd = BTC;
      else if (c == w + le + TWR) ecmd = PRC;
    end
    eack = (le != 0) && (c >= w) && (c < w + le);
    eend = (c == te);
    edq  = eack ? fifo_mem[12'(int'(base) + c - w)] : 16'h0000;

    check_val($sformatf("cmd c%0d", c), 32'(wr_cmd), 32'(ecmd));
    check_val($sformatf("ack c%0d", c), 32'(wr_ack), 32'(eack));
    check_val($sformatf("oe c%0d", c), 32'(wr_dq_oe), 32'(eack));
    check_val($sformatf("end c%0d", c), 32'(wr_end), 32'(eend));
    check_val($sformatf("dq c%0d", c), 32'(wr_dq), 32'(edq));
    if (ecmd == ACT) begin
      check_val("act ba", 32'(wr_ba), 32'(a[23:22]));
      check_val("act row", 32'(wr_sdram_addr), 32'(a[21:9]));
    end
    if (ecmd == WRC) begin
      check_val("wr ba", 32'(wr_ba), 32'(a[23:22]));
      check_val("wr col", 32'(wr_sdram_addr), 32'({4'b0, a[8:0]}));
    end
    if (ecmd == PRC) check_val("prech a10", 32'(wr_sdram_addr[10]), 32'd1);
  endtask

  // Called at a negedge with the DUT idle. disturb keeps wr_en high into DATA, then
  // drops it and scrambles wr_addr/wr_bst_len. rst_at > 0 asserts reset at that cycle.
  task automatic run_burst(input logic [23:0] a, input logic [9:0] len, input bit disturb,
                           input int rst_at);
    int          le;
    int          w;
    int          te;
    logic [11:0] base;
    le   = (int'(len) > 512) ? 512 : int'(len);
    w    = 1 + TRCD;
    te   = (le == 0) ? 1 : w + le + TWR + TRP;
    base = rd_ptr;
    wr_addr    = a;
    wr_bst_len = len;
    wr_en      = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= te + 1; c++) begin
      if (!disturb || c >= w + 1) wr_en = 1'b0;
      if (disturb && c == w + 1) begin
        wr_addr    = $urandom;
        wr_bst_len = 10'($urandom);
      end
      check_cycle(c, a, le, base);
      if (rst_at > 0 && c == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check_val("rst mid cmd", 32'(wr_cmd), 32'(NOP));
        check_val("rst mid ack", 32'(wr_ack), 32'd0);
        check_val("rst mid end", 32'(wr_end), 32'd0);
        check_val("rst mid oe", 32'(wr_dq_oe), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [23:0] ra;
    logic [9:0]  rl;
    for (int i = 0; i < 4096; i++) fifo_mem[i] = 16'($urandom);
    rst_n      = 1'b0;
    init_end   = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_bst_len = '0;

    // Reset
    repeat (3) @(negedge clk);
    check_val("rst cmd", 32'(wr_cmd), 32'(NOP));
    check_val("rst ack", 32'(wr_ack), 32'd0);
    check_val("rst end", 32'(wr_end), 32'd0);
    check_val("rst oe", 32'(wr_dq_oe), 32'd0);
    check_val("rst ba", 32'(wr_ba), 32'd0);
    check_val("rst addr", 32'(wr_sdram_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic, empty, full page, clamp, wrap, mid-burst disturbance
    run_burst(24'h40_0203, 10'd4, 1'b0, 0);
    run_burst(24'h12_3456, 10'd0, 1'b0, 0);
    run_burst(24'h80_0400, 10'd512, 1'b0, 0);
    run_burst(24'hC0_0600, 10'd600, 1'b0, 0);
    run_burst(24'h00_03FE, 10'd4, 1'b0, 0);
    run_burst(24'h7F_FE05, 10'd6, 1'b1, 0);

    // Grant ignored while init_end is low
    init_end = 1'b0;
    wr_addr  = 24'h40_0203;
    wr_bst_len = 10'd4;
    wr_en    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val($sformatf("gate cmd %0d", i), 32'(wr_cmd), 32'(NOP));
      check_val($sformatf("gate ack %0d", i), 32'(wr_ack), 32'd0);
      check_val($sformatf("gate end %0d", i), 32'(wr_end), 32'd0);
    end
    wr_en    = 1'b0;
    init_end = 1'b1;
    @(negedge clk);

    // Reset at beat 2, then the basic burst again
    run_burst(24'h40_0203, 10'd4, 1'b0, 1 + TRCD + 2);
    run_burst(24'h40_0203, 10'd4, 1'b0, 0);

    // Randomized bursts
    for (int n = 0; n < 12; n++) begin
      ra = 24'($urandom);
      rl = (n % 4 == 3) ? 10'($urandom) : 10'($urandom_range(0, 40));
      run_burst(ra, rl, bit'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
